stream_demux: RTL and testbench

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux_if.sv | 29 ++
 rtl/stream_demux.sv | 76 +++++++
 tb/tb_stream_demux.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_if.sv
// Stream demux bus: one upstream packet stream fanned out to N_OUT downstream ports.
// The slave modport is the demux side and the master modport is the driver/sink side.
interface stream_demux_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_OUT = 4
);
  localparam int unsigned SEL_W = $clog2(N_OUT);

  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_data;
  logic             up_last;
  logic [SEL_W-1:0] up_sel;
  logic [N_OUT-1:0] down_valid;
  logic [N_OUT-1:0] down_ready;
  logic [WIDTH-1:0] down_data;
  logic             down_last;
  logic             locked;

  modport slave (
    input  up_valid, up_data, up_last, up_sel, down_ready,
    output up_ready, down_valid, down_data, down_last, locked
  );

  modport master (
    output up_valid, up_data, up_last, up_sel, down_ready,
    input  up_ready, down_valid, down_data, down_last, locked
  );
endinterface

// File: rtl/stream_demux.sv
// Packet-aware stream demultiplexer: a packet's head picks the port, and the rest
// of the packet follows it through a single full-throughput output register.
module stream_demux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_OUT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_demux_if.slave   bus
);
  localparam int unsigned SEL_W = $clog2(N_OUT);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_lock_dst;
  logic             r_out_full;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [SEL_W-1:0] r_out_dst;

  logic             w_down_rdy;
  logic             w_up_ready;
  logic             w_accept;
  logic [SEL_W-1:0] w_route;
  logic [N_OUT-1:0] w_down_valid;

  // Only the ready of the port currently holding the beat matters.
  assign w_down_rdy = bus.down_ready[r_out_dst];
  assign w_up_ready = !r_out_full || w_down_rdy;
  assign w_accept   = bus.up_valid && w_up_ready;
  assign w_route    = (r_state == S_LOCKED) ? r_lock_dst : bus.up_sel;

  always_comb begin
    w_down_valid = '0;
    if (r_out_full) w_down_valid = N_OUT'(1) << r_out_dst;
  end

  // Output register plus head/body routing state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_lock_dst <= '0;
      r_out_full <= 1'b0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
      r_out_dst  <= '0;
    end else if (w_accept) begin
      r_out_full <= 1'b1;
      r_out_data <= bus.up_data;
      r_out_last <= bus.up_last;
      r_out_dst  <= w_route;
      case (r_state)
        S_IDLE: begin
          if (!bus.up_last) begin
            r_lock_dst <= bus.up_sel;
            r_state    <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (bus.up_last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end else if (r_out_full && w_down_rdy) begin
      r_out_full <= 1'b0;
    end
  end

  assign bus.up_ready   = w_up_ready;
  assign bus.down_valid = w_down_valid;
  assign bus.down_data  = r_out_data;
  assign bus.down_last  = r_out_last;
  assign bus.locked     = (r_state == S_LOCKED);

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: packet-level reference model with per-port
// delivery queues, checked every cycle, plus literal spot checks.
module tb_stream_demux;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned N_OUT = 4;
  localparam int unsigned SEL_W = $clog2(N_OUT);

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  stream_demux_if #(.WIDTH(WIDTH), .N_OUT(N_OUT)) bus ();

  stream_demux #(.WIDTH(WIDTH), .N_OUT(N_OUT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending beat and whether a packet is open.
  logic             m_full;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  int               m_dst;
  logic             m_in_pkt;
  int               m_pkt_dst;
  logic [WIDTH:0]   exp_q [N_OUT][$];
  int               deliv [N_OUT];

  always @(posedge clk or negedge rst_n) begin : model
    logic tx;
    logic acc;
    int   dst;
    if (!rst_n) begin
      m_full    <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      m_dst     <= 0;
      m_in_pkt  <= 1'b0;
      m_pkt_dst <= 0;
      for (int i = 0; i < N_OUT; i++) exp_q[i].delete();
    end else begin
      cyc <= cyc + 1;
      tx  = m_full && bus.down_ready[m_dst];
      acc = bus.up_valid && (!m_full || tx);
      if (acc) begin
        dst = m_in_pkt ? m_pkt_dst : int'(bus.up_sel);
        m_full <= 1'b1;
        m_data <= bus.up_data;
        m_last <= bus.up_last;
        m_dst  <= dst;
        exp_q[dst].push_back({bus.up_last, bus.up_data});
        m_in_pkt  <= !bus.up_last;
        m_pkt_dst <= dst;
      end else if (tx) begin
        m_full <= 1'b0;
      end
    end
  end

  // Per-cycle compare and per-port delivery scoreboard.
  always @(negedge clk) begin : compare
    logic [N_OUT-1:0] exp_dv;
    logic [WIDTH:0]   beat;
    if (rst_n === 1'b1) begin
      exp_dv = m_full ? (N_OUT'(1) << m_dst) : '0;
      chk("down_valid", 32'(bus.down_valid), 32'(exp_dv));
      chk("up_ready", 32'(bus.up_ready), 32'(!m_full || bus.down_ready[m_dst]));
      chk("locked", 32'(bus.locked), 32'(m_in_pkt));
      if (m_full) begin
        chk("down_data", 32'(bus.down_data), 32'(m_data));
        chk("down_last", 32'(bus.down_last), 32'(m_last));
      end
      for (int i = 0; i < N_OUT; i++) begin
        if (bus.down_valid[i] && bus.down_ready[i]) begin
          deliv[i]++;
          if (exp_q[i].size() == 0) begin
            chk("sb_unexpected_beat", 32'(i), 32'hFFFF_FFFF);
          end else begin
            beat = exp_q[i].pop_front();
            chk("sb_port_beat", 32'({bus.down_last, bus.down_data}), 32'(beat));
          end
        end
      end
    end
  end

  // Present one beat and hold it until it is accepted.
  task automatic send(input int sel, input logic [WIDTH-1:0] data, input logic last);
    logic acc;
    bus.up_valid = 1'b1;
    bus.up_sel   = SEL_W'(sel);
    bus.up_data  = data;
    bus.up_last  = last;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = bus.up_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic idle(input int n);
    bus.up_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int c0;
    int d0 [N_OUT];
    clk = 1'b0;
    checks = 0;
    errors = 0;
    cyc = 0;
    for (int i = 0; i < N_OUT; i++) deliv[i] = 0;
    rst_n = 1'b0;
    bus.up_valid   = 1'b0;
    bus.up_data    = '0;
    bus.up_last    = 1'b0;
    bus.up_sel     = '0;
    bus.down_ready = 4'hF;
    #1;
    chk("rst_down_valid", 32'(bus.down_valid), 32'h0);
    chk("rst_down_data", 32'(bus.down_data), 32'h0);
    chk("rst_down_last", 32'(bus.down_last), 32'h0);
    chk("rst_locked", 32'(bus.locked), 32'h0);
    chk("rst_up_ready", 32'(bus.up_ready), 32'h1);

    // Single beat to port 2, accepted on the first edge after reset release.
    repeat (2) @(negedge clk);
    bus.up_valid = 1'b1;
    bus.up_sel   = 2'd2;
    bus.up_data  = 8'hA5;
    bus.up_last  = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("single_dv", 32'(bus.down_valid), 32'h4);
    chk("single_data", 32'(bus.down_data), 32'hA5);
    chk("single_last", 32'(bus.down_last), 32'h1);
    chk("single_locked", 32'(bus.locked), 32'h0);
    idle(2);
    chk("single_drained", 32'(bus.down_valid), 32'h0);

    // Three-beat packet: body up_sel values must be ignored.
    send(1, 8'h11, 1'b0);
    chk("lock_b1_dv", 32'(bus.down_valid), 32'h2);
    chk("lock_b1_locked", 32'(bus.locked), 32'h1);
    send(3, 8'h22, 1'b0);
    chk("lock_b2_dv", 32'(bus.down_valid), 32'h2);
    chk("lock_b2_locked", 32'(bus.locked), 32'h1);
    send(0, 8'h33, 1'b1);
    chk("lock_b3_dv", 32'(bus.down_valid), 32'h2);
    chk("lock_b3_data", 32'(bus.down_data), 32'h33);
    chk("lock_b3_locked", 32'(bus.locked), 32'h0);

    // Backpressure on port 3 while other ports are ready.
    bus.down_ready = 4'b0111;
    idle(1);
    send(3, 8'hC3, 1'b1);
    bus.up_valid = 1'b1;
    bus.up_sel   = 2'd0;
    bus.up_data  = 8'h44;
    bus.up_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_dv", 32'(bus.down_valid), 32'h8);
      chk("bp_data", 32'(bus.down_data), 32'hC3);
      chk("bp_up_ready", 32'(bus.up_ready), 32'h0);
    end
    @(posedge clk);
    #1;
    bus.down_ready = 4'hF;
    send(0, 8'h44, 1'b1);
    chk("bp_next_dv", 32'(bus.down_valid), 32'h1);
    chk("bp_next_data", 32'(bus.down_data), 32'h44);
    idle(1);

    // Streaming: 16 single-beat packets, one per cycle.
    for (int i = 0; i < N_OUT; i++) d0[i] = deliv[i];
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      send(i % 4, 8'(8'h50 + i), 1'b1);
      chk("stream_dv", 32'(bus.down_valid), 32'(1 << (i % 4)));
      chk("stream_data", 32'(bus.down_data), 32'(8'h50 + i));
    end
    chk("stream_cycles", 32'(cyc - c0), 32'd16);
    idle(2);
    for (int i = 0; i < N_OUT; i++) chk("stream_port_count", 32'(deliv[i] - d0[i]), 32'd4);

    // Reset in the middle of a 4-beat packet to port 2.
    send(2, 8'h61, 1'b0);
    send(2, 8'h62, 1'b0);
    bus.up_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dv", 32'(bus.down_valid), 32'h0);
    chk("mid_rst_locked", 32'(bus.locked), 32'h0);
    chk("mid_rst_up_ready", 32'(bus.up_ready), 32'h1);
    repeat (2) @(negedge clk);
    bus.up_valid = 1'b1;
    bus.up_sel   = 2'd0;
    bus.up_data  = 8'h70;
    bus.up_last  = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_dv", 32'(bus.down_valid), 32'h1);
    chk("post_rst_data", 32'(bus.down_data), 32'h70);
    chk("post_rst_locked", 32'(bus.locked), 32'h0);
    idle(3);

    for (int i = 0; i < N_OUT; i++) chk("final_queue_empty", 32'(exp_q[i].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
